// File: rtl/luks_sample_buffer.sv
// luks_sample_buffer
//   Scheduler and consumer for the SPI light-sensor reader. Starts a conversion
//   request every SAMPLE_PERIOD cycles while enabled, captures the reader's byte,
//   stores it in a show-ahead FIFO for the host and keeps an exponential moving
//   average of all captured samples.
//
// Handshakes:
//   Reader side: spi_valid is a level request, high from REQ through CAPT. The
//   reader signals completion with a rising edge of spi_ready (level, it stays
//   high until the next request); spi_data is stable while spi_ready is high.
//   Host side: rd_data shows the FIFO head whenever empty=0; a pop happens on
//   any cycle with rd_en=1 and empty=0. rd_en while empty is ignored.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   enable                 1 = periodic sampling runs
//   spi_valid              request to reader
//   spi_ready, spi_data    reader done flag and result byte
//   rd_en, rd_data         host pop and FIFO head (0 while empty)
//   empty, full, count     FIFO status
//   avg, avg_valid         EMA integer part, set once first sample captured
//   overflow, timeout      sticky error flags, cleared by err_clr
//   err_clr                single-cycle clear of error flags
//   dbg_state              FSM state (0 IDLE, 1 REQ, 2 CAPT, 3 GAP)
module luks_sample_buffer #(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int TIMEOUT       = 2000,
  parameter int DEPTH_LOG2    = 4,
  parameter int AVG_SHIFT     = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  output logic                  spi_valid,
  input  logic                  spi_ready,
  input  logic [7:0]            spi_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            avg,
  output logic                  avg_valid,
  output logic                  overflow,
  output logic                  timeout,
  input  logic                  err_clr,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int PW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACC_W = 8 + AVG_SHIFT;
  localparam logic [PW-1:0]         PERIOD_RELOAD = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0]         TC_LAST       = TW'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_period;
  logic [TW-1:0]         r_tc;
  logic                  r_gap;
  logic                  r_ready_prev;
  logic                  w_edge;
  logic                  w_push;
  logic                  w_timeout_evt;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_write;
  logic                  w_overflow_evt;

  logic [ACC_W-1:0]      r_acc;
  logic                  r_avg_valid;
  logic                  r_overflow;
  logic                  r_timeout;

  // A rising edge only counts when the previous cycle was low, so a ready level
  // left over from the last frame cannot complete a new request.
  assign w_edge = spi_ready & ~r_ready_prev;

  always_comb begin
    w_next        = r_state;
    spi_valid     = 1'b0;
    w_push        = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && (r_period == '0)) w_next = ST_REQ;
      end
      ST_REQ: begin
        spi_valid = 1'b1;
        if (w_edge) begin
          w_next = ST_CAPT;
        end else if (r_tc == TC_LAST) begin
          w_timeout_evt = 1'b1;
          w_next        = ST_GAP;
        end
      end
      ST_CAPT: begin
        spi_valid = 1'b1;
        w_push    = 1'b1;
        w_next    = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tc         <= '0;
      r_gap        <= 1'b0;
      r_ready_prev <= 1'b0;
    end else begin
      r_tc         <= ((r_state == ST_REQ) && (w_next == ST_REQ)) ? r_tc + TW'(1) : '0;
      // r_gap marks the second GAP cycle.
      r_gap        <= (r_state == ST_GAP) && !r_gap;
      r_ready_prev <= spi_ready;
    end
  end

  // Period counter: reloads when a request starts and counts down in every
  // state; dropping enable parks it at 0 so re-enabling requests immediately.
  always_ff @(posedge clk) begin
    if (!rstn || !enable) begin
      r_period <= '0;
    end else if ((r_state == ST_IDLE) && (r_period == '0)) begin
      r_period <= PERIOD_RELOAD;
    end else if (r_period != '0) begin
      r_period <= r_period - PW'(1);
    end
  end

  // FIFO. A push into a full FIFO still succeeds when a pop frees the head slot
  // in the same cycle; otherwise the sample is dropped.
  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == CNT_FULL);
  assign w_pop          = rd_en && !w_empty;
  assign w_write        = w_push && (!w_full || w_pop);
  assign w_overflow_evt = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rstn && w_write) r_mem[r_wr_ptr] <= spi_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // EMA: every captured sample is folded in, including ones the FIFO drops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_avg_valid <= 1'b0;
    end else if (w_push) begin
      r_avg_valid <= 1'b1;
      if (!r_avg_valid) r_acc <= ACC_W'(spi_data) << AVG_SHIFT;
      else              r_acc <= r_acc - (r_acc >> AVG_SHIFT) + ACC_W'(spi_data);
    end
  end

  // Sticky flags: a new event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_overflow_evt) r_overflow <= 1'b1;
      else if (err_clr)   r_overflow <= 1'b0;
      if (w_timeout_evt)  r_timeout  <= 1'b1;
      else if (err_clr)   r_timeout  <= 1'b0;
    end
  end

  assign rd_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign avg       = r_acc[AVG_SHIFT +: 8];
  assign avg_valid = r_avg_valid;
  assign overflow  = r_overflow;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule
